// File: rtl/sbqm_pkg.sv
// Shared types and helpers for the multi-channel queue occupancy counter.
// Event encoding and total-width helper live here.
package sbqm_pkg;

    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_INC  = 2'b01,
        EV_DEC  = 2'b10,
        EV_BOTH = 2'b11
    } occ_ev_e;

    function automatic int occ_total_w(input int n, input int nch);
        return n + $clog2(nch + 1);
    endfunction

endpackage

// File: rtl/occ_chan.sv
// One occupancy channel: sensor synchronisers, rising-edge detect,
// saturating counter with full/empty/almost-full and sticky error flags.
module occ_chan
    import sbqm_pkg::*;
#(
    parameter int N           = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc_lvl,
    input  logic         dec_lvl,
    input  logic         clr_cnt,
    input  logic         clr_flags,
    input  logic [N-1:0] afull_thresh,
    output logic [N-1:0] count,
    output logic         full,
    output logic         empty,
    output logic         afull,
    output logic         ovf,
    output logic         unf
);

    localparam logic [N-1:0] MAX = '1;

    logic    inc_s;
    logic    dec_s;
    logic    inc_prev;
    logic    dec_prev;
    occ_ev_e ev;

    // Sync flops reset high so a sensor held through reset is not counted.
    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] inc_sync;
        logic [SYNC_STAGES-1:0] dec_sync;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                inc_sync <= '1;
                dec_sync <= '1;
            end else begin
                inc_sync[0] <= inc_lvl;
                dec_sync[0] <= dec_lvl;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    inc_sync[i] <= inc_sync[i-1];
                    dec_sync[i] <= dec_sync[i-1];
                end
            end
        end

        assign inc_s = inc_sync[SYNC_STAGES-1];
        assign dec_s = dec_sync[SYNC_STAGES-1];
    end else begin : g_nosync
        assign inc_s = inc_lvl;
        assign dec_s = dec_lvl;
    end

    assign ev    = occ_ev_e'({dec_s & ~dec_prev, inc_s & ~inc_prev});
    assign full  = (count == MAX);
    assign empty = (count == '0);
    assign afull = (count >= afull_thresh);

    // Flag clear comes first so a same-cycle set overrides it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_prev <= 1'b1;
            dec_prev <= 1'b1;
            count    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            inc_prev <= inc_s;
            dec_prev <= dec_s;
            if (clr_flags) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (clr_cnt) begin
                count <= '0;
            end else begin
                unique case (ev)
                    EV_INC: begin
                        if (full) ovf <= 1'b1;
                        else      count <= count + 1'b1;
                    end
                    EV_DEC: begin
                        if (empty) unf <= 1'b1;
                        else       count <= count - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/queue_occupancy_counter.sv
// Multi-channel queue occupancy counter: NCH independent saturating
// channels sharing clear controls and threshold, plus an aggregate total.
module queue_occupancy_counter
    import sbqm_pkg::*;
#(
    parameter int N           = 3,
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NCH-1:0]                     inc_lvl,
    input  logic [NCH-1:0]                     dec_lvl,
    input  logic                               clr_cnt,
    input  logic                               clr_flags,
    input  logic [N-1:0]                       afull_thresh,
    output logic [NCH-1:0][N-1:0]              count,
    output logic [NCH-1:0]                     full,
    output logic [NCH-1:0]                     empty,
    output logic [NCH-1:0]                     afull,
    output logic [NCH-1:0]                     ovf,
    output logic [NCH-1:0]                     unf,
    output logic [occ_total_w(N, NCH)-1:0]     total
);

    localparam int TW = occ_total_w(N, NCH);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        occ_chan #(
            .N           (N),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk          (clk),
            .reset_n      (reset_n),
            .inc_lvl      (inc_lvl[c]),
            .dec_lvl      (dec_lvl[c]),
            .clr_cnt      (clr_cnt),
            .clr_flags    (clr_flags),
            .afull_thresh (afull_thresh),
            .count        (count[c]),
            .full         (full[c]),
            .empty        (empty[c]),
            .afull        (afull[c]),
            .ovf          (ovf[c]),
            .unf          (unf[c])
        );
    end

    always_comb begin
        total = '0;
        for (int c = 0; c < NCH; c++) begin
            total = total + TW'(count[c]);
        end
    end

endmodule

// File: tb/tb_queue_occupancy_counter.sv
// Directed self-checking bench for queue_occupancy_counter (N=3, NCH=2).
module tb_queue_occupancy_counter;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      inc_lvl;
    logic [1:0]      dec_lvl;
    logic            clr_cnt;
    logic            clr_flags;
    logic [2:0]      afull_thresh;
    logic [1:0][2:0] count;
    logic [1:0]      full;
    logic [1:0]      empty;
    logic [1:0]      afull;
    logic [1:0]      ovf;
    logic [1:0]      unf;
    logic [4:0]      total;

    int checks = 0;
    int fails  = 0;

    queue_occupancy_counter #(
        .N           (3),
        .NCH         (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .inc_lvl      (inc_lvl),
        .dec_lvl      (dec_lvl),
        .clr_cnt      (clr_cnt),
        .clr_flags    (clr_flags),
        .afull_thresh (afull_thresh),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .afull        (afull),
        .ovf          (ovf),
        .unf          (unf),
        .total        (total)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle sensor pulse, then wait for it to land in the count.
    task automatic pulse(input bit is_inc, input int ch);
        if (is_inc) inc_lvl[ch] = 1'b1;
        else        dec_lvl[ch] = 1'b1;
        tick(1);
        if (is_inc) inc_lvl[ch] = 1'b0;
        else        dec_lvl[ch] = 1'b0;
        tick(3);
    endtask

    task automatic do_clr_cnt();
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        inc_lvl      = 2'b01;
        dec_lvl      = 2'b00;
        clr_cnt      = 1'b0;
        clr_flags    = 1'b0;
        afull_thresh = 3'd5;
        tick(3);
        checks++;
        if (count !== 6'd0 || empty !== 2'b11 || full !== 2'b00 ||
            total !== 5'd0 || ovf !== 2'b00 || unf !== 2'b00) begin
            fails++;
            $display("FAIL reset_state: count=%h empty=%b full=%b total=%0d ovf=%b unf=%b",
                     count, empty, full, total, ovf, unf);
        end
        reset_n = 1'b1;
        tick(10);
        checks++;
        if (count[0] !== 3'd0 || empty[0] !== 1'b1) begin
            fails++;
            $display("FAIL held_high: count0=%0d empty0=%b want 0/1", count[0], empty[0]);
        end
        inc_lvl[0] = 1'b0;
        tick(4);
        inc_lvl[0] = 1'b1;
        tick(2);
        checks++;
        if (count[0] !== 3'd0) begin
            fails++;
            $display("FAIL latency_early: count0=%0d want 0", count[0]);
        end
        tick(1);
        checks++;
        if (count[0] !== 3'd1) begin
            fails++;
            $display("FAIL latency_edge: count0=%0d want 1", count[0]);
        end
        tick(5);
        checks++;
        if (count[0] !== 3'd1) begin
            fails++;
            $display("FAIL level_once: count0=%0d want 1", count[0]);
        end
        inc_lvl[0] = 1'b0;
        tick(3);
    endtask

    task automatic test_overflow();
        do_clr_cnt();
        for (int i = 0; i < 7; i++) pulse(1'b1, 0);
        checks++;
        if (count[0] !== 3'd7 || full[0] !== 1'b1 || ovf[0] !== 1'b0) begin
            fails++;
            $display("FAIL fill_7: count0=%0d full0=%b ovf0=%b want 7/1/0",
                     count[0], full[0], ovf[0]);
        end
        pulse(1'b1, 0);
        checks++;
        if (count[0] !== 3'd7 || ovf[0] !== 1'b1) begin
            fails++;
            $display("FAIL overflow: count0=%0d ovf0=%b want 7/1", count[0], ovf[0]);
        end
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        checks++;
        if (ovf[0] !== 1'b0 || count[0] !== 3'd7) begin
            fails++;
            $display("FAIL clr_flags_ovf: ovf0=%b count0=%0d want 0/7", ovf[0], count[0]);
        end
    endtask

    task automatic test_underflow();
        pulse(1'b0, 1);
        checks++;
        if (unf !== 2'b10 || count[1] !== 3'd0) begin
            fails++;
            $display("FAIL underflow: unf=%b count1=%0d want 10/0", unf, count[1]);
        end
        dec_lvl[1] = 1'b1;
        tick(2);
        clr_flags = 1'b1;
        tick(1);
        clr_flags  = 1'b0;
        dec_lvl[1] = 1'b0;
        checks++;
        if (unf[1] !== 1'b1 || count[1] !== 3'd0) begin
            fails++;
            $display("FAIL set_beats_clr: unf1=%b count1=%0d want 1/0", unf[1], count[1]);
        end
        tick(3);
    endtask

    task automatic test_simultaneous();
        do_clr_cnt();
        for (int i = 0; i < 3; i++) pulse(1'b1, 0);
        inc_lvl[0] = 1'b1;
        dec_lvl[0] = 1'b1;
        tick(1);
        inc_lvl[0] = 1'b0;
        dec_lvl[0] = 1'b0;
        tick(3);
        checks++;
        if (count[0] !== 3'd3 || ovf[0] !== 1'b0 || unf[0] !== 1'b0) begin
            fails++;
            $display("FAIL both_edges: count0=%0d ovf0=%b unf0=%b want 3/0/0",
                     count[0], ovf[0], unf[0]);
        end
        pulse(1'b1, 0);
        checks++;
        if (count[0] !== 3'd4) begin
            fails++;
            $display("FAIL sep_inc: count0=%0d want 4", count[0]);
        end
        pulse(1'b0, 0);
        checks++;
        if (count[0] !== 3'd3) begin
            fails++;
            $display("FAIL sep_dec: count0=%0d want 3", count[0]);
        end
    endtask

    task automatic test_afull_total();
        afull_thresh = 3'd5;
        do_clr_cnt();
        for (int i = 0; i < 5; i++) pulse(1'b1, 0);
        for (int i = 0; i < 2; i++) pulse(1'b1, 1);
        checks++;
        if (afull !== 2'b01 || total !== 5'd7 || full !== 2'b00 || empty !== 2'b00) begin
            fails++;
            $display("FAIL afull_5: afull=%b total=%0d full=%b empty=%b want 01/7/00/00",
                     afull, total, full, empty);
        end
        afull_thresh = 3'd2;
        #1;
        checks++;
        if (afull !== 2'b11) begin
            fails++;
            $display("FAIL afull_eq: afull=%b want 11", afull);
        end
        afull_thresh = 3'd5;
        inc_lvl[0] = 1'b1;
        tick(2);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt    = 1'b0;
        inc_lvl[0] = 1'b0;
        tick(3);
        checks++;
        if (count !== 6'd0 || total !== 5'd0 || empty !== 2'b11 || unf !== 2'b10 ||
            ovf !== 2'b00) begin
            fails++;
            $display("FAIL clr_cnt_ev: count=%h total=%0d empty=%b unf=%b ovf=%b",
                     count, total, empty, unf, ovf);
        end
        afull_thresh = 3'd0;
        #1;
        checks++;
        if (afull !== 2'b11) begin
            fails++;
            $display("FAIL afull_zero: afull=%b want 11", afull);
        end
        afull_thresh = 3'd5;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) pulse(1'b1, 0);
        checks++;
        if (count[0] !== 3'd4) begin
            fails++;
            $display("FAIL pre_reset: count0=%0d want 4", count[0]);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 6'd0 || total !== 5'd0 || unf !== 2'b00 || empty !== 2'b11) begin
            fails++;
            $display("FAIL async_reset: count=%h total=%0d unf=%b empty=%b",
                     count, total, unf, empty);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(4);
        checks++;
        if (count !== 6'd0) begin
            fails++;
            $display("FAIL post_reset: count=%h want 0", count);
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_afull_total();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
